// File: rtl/frameset_seq_if.sv
// Bundle of the frameset sequencer's streaming and status signals.
// The sequencer connects through the slave modport; whatever drives it
// (sample source, sync/derotate datapath, sink, status reader) uses master.
interface frameset_seq_if #(
  parameter int INPUT_SIZE = 8
);
  // upstream sample stream
  logic                         enable_in;
  logic signed [INPUT_SIZE-1:0] soft_in;
  logic                         soft_valid_in;
  logic                         soft_ready_out;

  // towards the sync/derotate datapath
  logic signed [INPUT_SIZE-1:0] sync_soft_out;
  logic                         sync_valid_out;
  logic                         sync_ready_in;
  logic                         sync_rst_out;
  logic                         sync_tx_ready_out;

  // back from the sync/derotate datapath
  logic                         sync_pair_valid_in;
  logic signed [INPUT_SIZE-1:0] sync_pair0_in;
  logic signed [INPUT_SIZE-1:0] sync_pair1_in;
  logic                         sync_new_frameset_in;
  logic                         sync_last_in;

  // downstream pair stream
  logic                         pair_valid_out;
  logic signed [INPUT_SIZE-1:0] pair0_out;
  logic signed [INPUT_SIZE-1:0] pair1_out;
  logic                         pair_first_out;
  logic                         pair_last_out;
  logic                         pair_ready_in;

  // status
  logic                         busy_out;
  logic [15:0]                  frameset_cnt_out;
  logic [7:0]                   timeout_cnt_out;
  logic                         len_err_out;

  // sequencer side
  modport slave (
    input  enable_in, soft_in, soft_valid_in,
    output soft_ready_out,
    output sync_soft_out, sync_valid_out, sync_rst_out, sync_tx_ready_out,
    input  sync_ready_in,
    input  sync_pair_valid_in, sync_pair0_in, sync_pair1_in,
    input  sync_new_frameset_in, sync_last_in,
    output pair_valid_out, pair0_out, pair1_out, pair_first_out, pair_last_out,
    input  pair_ready_in,
    output busy_out, frameset_cnt_out, timeout_cnt_out, len_err_out
  );

  // environment side
  modport master (
    output enable_in, soft_in, soft_valid_in,
    input  soft_ready_out,
    input  sync_soft_out, sync_valid_out, sync_rst_out, sync_tx_ready_out,
    output sync_ready_in,
    output sync_pair_valid_in, sync_pair0_in, sync_pair1_in,
    output sync_new_frameset_in, sync_last_in,
    input  pair_valid_out, pair0_out, pair1_out, pair_first_out, pair_last_out,
    output pair_ready_in,
    input  busy_out, frameset_cnt_out, timeout_cnt_out, len_err_out
  );
endinterface

// File: rtl/frameset_seq.sv
// Frameset sequencer: admits exactly N soft samples into the sync/derotate
// datapath, then drains its N/2 output pairs to the sink. A drain watchdog
// resets a datapath that stops producing pairs; stalls by the sink are not
// treated as a hang. Status counters report completed framesets, watchdog
// recoveries and a sticky pair-count error.
module frameset_seq #(
  parameter int INPUT_SIZE     = 8,
  parameter int BITS_PER_FRAME = 80,
  parameter int NUM_FRAMES     = 32,
  parameter int WDOG_CYCLES    = 4096
) (
  input logic           clk,
  input logic           rst_in,
  frameset_seq_if.slave bus
);

  localparam int N        = BITS_PER_FRAME * NUM_FRAMES;
  localparam int P        = N / 2;
  localparam int SAMPLE_W = (N > 2) ? $clog2(N) : 1;
  localparam int PAIR_W   = $clog2(P + 1);
  localparam int WDOG_W   = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    DRAIN   = 2'd2,
    RECOVER = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic [SAMPLE_W-1:0] sample_reg, sample_next;
  logic [PAIR_W-1:0]   pair_reg, pair_next;
  logic [WDOG_W-1:0]   wdog_reg, wdog_next;
  logic                rec_reg, rec_next;
  logic [15:0]         frameset_reg, frameset_next;
  logic [7:0]          timeout_reg, timeout_next;
  logic                len_err_reg, len_err_next;

  logic                         soft_ready;
  logic                         sync_valid;
  logic signed [INPUT_SIZE-1:0] sync_soft;
  logic                         tx_ready;
  logic                         pair_valid;
  logic signed [INPUT_SIZE-1:0] pair0;
  logic signed [INPUT_SIZE-1:0] pair1;
  logic                         pair_first;
  logic                         pair_last;

  // State and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_reg    <= IDLE;
      sample_reg   <= '0;
      pair_reg     <= '0;
      wdog_reg     <= '0;
      rec_reg      <= 1'b0;
      frameset_reg <= '0;
      timeout_reg  <= '0;
      len_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      sample_reg   <= sample_next;
      pair_reg     <= pair_next;
      wdog_reg     <= wdog_next;
      rec_reg      <= rec_next;
      frameset_reg <= frameset_next;
      timeout_reg  <= timeout_next;
      len_err_reg  <= len_err_next;
    end
  end

  // Next-state, counter updates and state-gated passthroughs
  always_comb begin
    state_next    = state_reg;
    sample_next   = sample_reg;
    pair_next     = pair_reg;
    wdog_next     = wdog_reg;
    rec_next      = rec_reg;
    frameset_next = frameset_reg;
    timeout_next  = timeout_reg;
    len_err_next  = len_err_reg;

    soft_ready = 1'b0;
    sync_valid = 1'b0;
    sync_soft  = '0;
    tx_ready   = 1'b0;
    pair_valid = 1'b0;
    pair0      = '0;
    pair1      = '0;
    pair_first = 1'b0;
    pair_last  = 1'b0;

    unique case (state_reg)
      IDLE: begin
        // enable only gates the start of a frameset, never an ongoing one
        if (bus.enable_in && bus.sync_ready_in) begin
          sample_next = '0;
          pair_next   = '0;
          state_next  = LOAD;
        end
      end

      LOAD: begin
        soft_ready = 1'b1;
        sync_valid = bus.soft_valid_in;
        sync_soft  = bus.soft_in;
        if (bus.soft_valid_in) begin
          sample_next = sample_reg + SAMPLE_W'(1);
          if (sample_reg == SAMPLE_W'(N - 1)) begin
            wdog_next  = '0;
            state_next = DRAIN;
          end
        end
      end

      DRAIN: begin
        tx_ready   = bus.pair_ready_in;
        pair_valid = bus.sync_pair_valid_in;
        pair0      = bus.sync_pair0_in;
        pair1      = bus.sync_pair1_in;
        pair_first = bus.sync_new_frameset_in;
        pair_last  = bus.sync_last_in;
        if (bus.sync_pair_valid_in) begin
          // a beat always wins over a coincident watchdog expiry
          pair_next = pair_reg + PAIR_W'(1);
          wdog_next = '0;
          if (bus.sync_new_frameset_in && (pair_reg != '0)) begin
            len_err_next = 1'b1;
          end
          if (bus.sync_last_in) begin
            frameset_next = frameset_reg + 16'd1;
            if ((pair_reg + PAIR_W'(1)) != PAIR_W'(P)) begin
              len_err_next = 1'b1;
            end
            state_next = IDLE;
          end
        end else if (bus.pair_ready_in) begin
          // only cycles where the sink could take a pair count towards a hang
          if (wdog_reg == WDOG_W'(WDOG_CYCLES - 1)) begin
            timeout_next = timeout_reg + 8'd1;
            rec_next     = 1'b0;
            state_next   = RECOVER;
          end else begin
            wdog_next = wdog_reg + WDOG_W'(1);
          end
        end
      end

      RECOVER: begin
        // two cycles of datapath reset, then back to IDLE
        if (rec_reg) begin
          state_next = IDLE;
        end else begin
          rec_next = 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.soft_ready_out    = soft_ready;
  assign bus.sync_valid_out    = sync_valid;
  assign bus.sync_soft_out     = sync_soft;
  assign bus.sync_tx_ready_out = tx_ready;
  assign bus.sync_rst_out      = rst_in | (state_reg == RECOVER);

  assign bus.pair_valid_out    = pair_valid;
  assign bus.pair0_out         = pair0;
  assign bus.pair1_out         = pair1;
  assign bus.pair_first_out    = pair_first;
  assign bus.pair_last_out     = pair_last;

  assign bus.busy_out          = (state_reg != IDLE);
  assign bus.frameset_cnt_out  = frameset_reg;
  assign bus.timeout_cnt_out   = timeout_reg;
  assign bus.len_err_out       = len_err_reg;

endmodule

// File: doc/frameset_seq.md
FRAMESET_SEQ -- requirements
Module: frameset_seq

Interface
REQ-001 SHALL have parameters: INPUT_SIZE, 8, soft sample width; BITS_PER_FRAME, 80, symbols per frame; NUM_FRAMES, 32, frames per frameset; WDOG_CYCLES, 4096, drain watchdog limit in cycles.
REQ-002 SHALL use one clock and a synchronous, active-high reset:
 clk  in  1  clock;
 rst_in  in  1  reset.
REQ-003 SHALL have these upstream ports:
 enable_in  in  1  permits new framesets;
 soft_in  in  INPUT_SIZE  signed soft sample;
 soft_valid_in  in  1  sample valid;
 soft_ready_out  out  1  sample accepted when high with soft_valid_in.
REQ-004 SHALL have these ports to the sync/derotate datapath:
 sync_soft_out  out  INPUT_SIZE  sample;
 sync_valid_out  out  1  sample valid;
 sync_ready_in  in  1  datapath ready for a frameset;
 sync_rst_out  out  1  datapath reset;
 sync_tx_ready_out  out  1  downstream ready, forwarded to the datapath.
REQ-005 SHALL have these ports from the sync/derotate datapath:
 sync_pair_valid_in  in  1  pair valid;
 sync_pair0_in  in  INPUT_SIZE  first soft value of the pair;
 sync_pair1_in  in  INPUT_SIZE  second soft value of the pair;
 sync_new_frameset_in  in  1  first pair of a frameset;
 sync_last_in  in  1  last pair of a frameset.
REQ-006 SHALL have these downstream ports:
 pair_valid_out  out  1  pair valid;
 pair0_out  out  INPUT_SIZE  first soft value;
 pair1_out  out  INPUT_SIZE  second soft value;
 pair_first_out  out  1  first pair of a frameset;
 pair_last_out  out  1  last pair of a frameset;
 pair_ready_in  in  1  downstream ready.
REQ-007 SHALL have these status ports:
 busy_out  out  1  state is not IDLE;
 frameset_cnt_out  out  16  completed framesets;
 timeout_cnt_out  out  8  watchdog recoveries;
 len_err_out  out  1  sticky: wrong pair count.

Function
REQ-008 SHALL define N = BITS_PER_FRAME*NUM_FRAMES (2560 by default) and P = N/2 pairs per frameset.
REQ-009 SHALL implement the states IDLE, LOAD, DRAIN and RECOVER.
REQ-010 IDLE: when enable_in=1 and sync_ready_in=1, the block SHALL clear the sample counter and the pair counter and move to LOAD on the next cycle.
REQ-011 LOAD: the block SHALL drive soft_ready_out=1 and sync_valid_out=soft_valid_in, with sync_soft_out=soft_in combinationally.
REQ-012 In LOAD, each cycle with soft_valid_in=1 SHALL increment the sample counter.
REQ-013 In LOAD, when the accepted sample is number N-1, the block SHALL go to DRAIN.
REQ-014 The datapath SHALL receive exactly N samples per frameset.
REQ-015 In every state except LOAD, soft_ready_out and sync_valid_out SHALL be 0.
REQ-016 DRAIN: the block SHALL pass pair_valid_out, pair0_out, pair1_out, pair_first_out and pair_last_out combinationally from the sync_* inputs.
REQ-017 In every state except DRAIN, pair_valid_out, pair_first_out and pair_last_out SHALL be 0.
REQ-018 sync_tx_ready_out SHALL equal pair_ready_in in DRAIN and SHALL be 0 otherwise.
REQ-019 In DRAIN, a beat (pair_valid_out=1) SHALL increment the pair counter.
REQ-020 In DRAIN, a beat with sync_last_in=1 SHALL increment frameset_cnt_out and return the block to IDLE.
REQ-021 On that last beat, if the pair count including the beat is not P, len_err_out SHALL be set.
REQ-022 A beat with sync_new_frameset_in=1 when the pair counter is not 0 SHALL also set len_err_out.
REQ-023 The watchdog counter SHALL clear on entry to DRAIN and on each beat.
REQ-024 The watchdog counter SHALL hold while pair_ready_in=0, because downstream stalls are not faults.
REQ-025 The watchdog counter SHALL otherwise increment each DRAIN cycle.
REQ-026 When the watchdog counter reaches WDOG_CYCLES-1, the block SHALL go to RECOVER and increment timeout_cnt_out.
REQ-027 RECOVER: sync_rst_out SHALL be 1 for exactly 2 cycles, then the block SHALL go to IDLE.
REQ-028 sync_rst_out SHALL equal rst_in OR (state==RECOVER).
REQ-029 Deasserting enable_in SHALL NOT abort LOAD or DRAIN; it only blocks the IDLE->LOAD transition.
REQ-030 frameset_cnt_out and timeout_cnt_out SHALL wrap modulo 2^16 and 2^8 respectively.
REQ-031 If a beat and watchdog expiry fall on the same cycle, the beat SHALL take priority and the watchdog SHALL not fire.
REQ-032 sync_last_in arriving in LOAD or IDLE SHALL be ignored and SHALL NOT be counted.
REQ-033 busy_out SHALL be 1 in LOAD, DRAIN and RECOVER.

Reset
REQ-034 When rst_in=1, the state SHALL become IDLE and all counters, len_err_out and busy_out SHALL become 0 on the next edge.
REQ-035 A reset in the middle of a frameset SHALL abandon it: sync_rst_out=1 during the reset and no frameset is counted.
REQ-036 After reset, all outputs SHALL be 0 except the combinational passthroughs, which are also 0 because the state is IDLE.

Verification
REQ-037 Nominal: sync_ready_in=1, then 2560 valid samples, then 1280 pairs with last on pair 1280 -> exactly 2560 sync_valid_out beats, frameset_cnt_out=1, len_err_out=0, return to IDLE.
REQ-038 Gapped input: soft_valid_in toggling 50% -> still exactly 2560 sync_valid_out beats and DRAIN entered after sample 2559.
REQ-039 Short frameset: last on pair 1000 -> len_err_out=1, frameset_cnt_out=1, IDLE.
REQ-040 Hang: no pairs for 4096 cycles with pair_ready_in=1 -> sync_rst_out high for 2 cycles, timeout_cnt_out=1, IDLE; with pair_ready_in=0 for 10000 cycles -> no timeout.
REQ-041 enable_in dropped during LOAD -> the frameset completes and no new LOAD starts while sync_ready_in=1.
REQ-042 rst_in pulsed at sample 1200 -> IDLE, counters 0, next frameset counts correctly.
